// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_pkg
// Brief    : Shared widths, constants and helpers for the covox/beeper mixer.
// Revision : 1.0 - initial release
// ============================================================================
package audio_pkg;

  localparam int MIX_W    = 10;
  localparam int SAMPLE_W = 8;

  localparam logic [SAMPLE_W-1:0] COVOX_MID = 8'h80;
  localparam logic [MIX_W-1:0]    MIX_MAX   = 10'h3FF;

  typedef logic [MIX_W-1:0]    mix_t;
  typedef logic [SAMPLE_W-1:0] sample_t;

  // Clamp the one-bit-wider raw mix back into the modulator range.
  function automatic mix_t sat_mix(input logic [MIX_W:0] raw);
    return raw[MIX_W] ? MIX_MAX : raw[MIX_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/strobe_sync.sv
`default_nettype none
// ============================================================================
// Module   : strobe_sync
// Brief    : Two-flop synchroniser with a one-cycle falling-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_fall = r_s3 & ~r_s2;

endmodule
`default_nettype wire

// File: rtl/covox_beeper_sdm.sv
`default_nettype none
// ============================================================================
// Module   : covox_beeper_sdm
// Brief    : Covox sample latch, beeper/tapeout mixer and first-order
//            sigma-delta DAC. Optional sample FIFO: define COVOX_FIFO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module covox_beeper_sdm
  import audio_pkg::*;
#(
  parameter mix_t BEEP_LVL   = 10'd256,
  parameter mix_t TAPE_LVL   = 10'd64,
  parameter int   SAMPLE_DIV = 160,
  parameter int   FIFO_DEPTH = 4
) (
  input  logic       cpu_clock,
  input  logic       reset,
  input  logic       covox_sel,
  input  logic [7:0] d,
  input  logic       beeper,
  input  logic       tapeout,
  output logic       audio_out,
  output logic [2:0] fifo_level
);

  // fifo_level is 3 bits, so only power-of-two depths up to 4 are representable.
  if (!((FIFO_DEPTH == 2 || FIFO_DEPTH == 4) && SAMPLE_DIV >= 2)) begin : g_cfg_check
    $error("covox_beeper_sdm: unsupported FIFO_DEPTH/SAMPLE_DIV");
  end

  sample_t        r_d_hold;
  sample_t        r_cur_sample;
  logic           w_commit;
  logic [MIX_W:0] w_mix_raw;
  mix_t           w_mix;
  mix_t           r_acc;
  logic [MIX_W:0] w_sum;

  strobe_sync u_covox_sync (
    .clk     (cpu_clock),
    .rst_n   (reset),
    .i_async (covox_sel),
    .o_fall  (w_commit)
  );

  // Last byte seen while the strobe is high is the one committed.
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      r_d_hold <= COVOX_MID;
    end else if (covox_sel) begin
      r_d_hold <= d;
    end
  end

`ifdef COVOX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int DIV_W = $clog2(SAMPLE_DIV);

  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  sample_t          r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [2:0]       r_level;
  logic             w_pop;
  logic             w_push;

  assign w_tick = (r_div == DIV_W'(SAMPLE_DIV - 1));
  assign w_pop  = w_tick && (r_level != 3'd0);
  // A full FIFO still accepts a push when the same cycle pops.
  assign w_push = w_commit && ((r_level != 3'(FIFO_DEPTH)) || w_pop);

  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= COVOX_MID;
      end
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= 3'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= r_d_hold;
        r_wr        <= r_wr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 3'd1;
        2'b01:   r_level <= r_level - 3'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      r_cur_sample <= COVOX_MID;
    end else if (w_pop) begin
      r_cur_sample <= r_mem[r_rd];
    end
  end

  assign fifo_level = r_level;
`else
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      r_cur_sample <= COVOX_MID;
    end else if (w_commit) begin
      r_cur_sample <= r_d_hold;
    end
  end

  assign fifo_level = 3'd0;
`endif

  assign w_mix_raw = (MIX_W+1)'({r_cur_sample, 1'b0})
                   + (beeper  ? (MIX_W+1)'(BEEP_LVL) : '0)
                   + (tapeout ? (MIX_W+1)'(TAPE_LVL) : '0);
  assign w_mix     = sat_mix(w_mix_raw);

  // Carry out of the phase accumulator is the output bit; density = mix/1024.
  assign w_sum = {1'b0, r_acc} + {1'b0, w_mix};

  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      r_acc     <= '0;
      audio_out <= 1'b0;
    end else begin
      r_acc     <= w_sum[MIX_W-1:0];
      audio_out <= w_sum[MIX_W];
    end
  end

endmodule
`default_nettype wire
